// File: rtl/btn_opcode_sel.sv
// Five raw pushbuttons -> synchronized, debounced levels -> priority-encoded 3-bit ALU opcode.
// HOLD selects between latching the last press and following the held buttons.
module btn_opcode_sel #(
   parameter int DB_CYCLES = 100000,
   parameter int CNT_W     = 17,
   parameter int HOLD      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnC,
   output logic [2:0] alu_control,
   output logic       op_valid,
   output logic [4:0] btn_stable
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [4:0] btn_raw;
   logic [4:0] sync_1;
   logic [4:0] sync_2;
   logic [4:0] stable_d;
   logic [4:0] press;
   logic [2:0] nxt_op;
   logic       nxt_valid;

   assign btn_raw = {btnC, btnR, btnL, btnD, btnU};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= btn_raw;
         sync_2 <= sync_1;
      end
   end

   // Each button owns its counter; any return to the stable level restarts the count.
   for (genvar i = 0; i < 5; i++) begin : g_db
      logic [CNT_W-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt           <= '0;
            btn_stable[i] <= 1'b0;
         end else if (sync_2[i] == btn_stable[i]) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt           <= '0;
            btn_stable[i] <= sync_2[i];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stable_d <= '0;
      else        stable_d <= btn_stable;
   end

   assign press = btn_stable & ~stable_d;

   function automatic logic [2:0] enc(input logic [4:0] v);
      if      (v[0]) return 3'b001;
      else if (v[1]) return 3'b010;
      else if (v[2]) return 3'b011;
      else if (v[3]) return 3'b100;
      else if (v[4]) return 3'b101;
      else           return 3'b000;
   endfunction

   always_comb begin
      nxt_op    = alu_control;
      nxt_valid = 1'b0;
      if (HOLD != 0) begin
         if (|press) begin
            nxt_op    = enc(press);
            nxt_valid = 1'b1;
         end
      end else begin
         nxt_op    = enc(btn_stable);
         nxt_valid = (nxt_op != alu_control);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_control <= 3'b000;
         op_valid    <= 1'b0;
      end else begin
         alu_control <= nxt_op;
         op_valid    <= nxt_valid;
      end
   end

endmodule
